// File: rtl/if_fetch_if.sv
// Instruction-memory bus between the fetch stage (master) and instruction memory (slave).
// inst_rdata is valid in the same cycle that inst_ack is high.
interface if_fetch_if;
  logic        inst_req;
  logic [31:0] inst_addr;
  logic        inst_ack;
  logic [31:0] inst_rdata;

  modport master (
    output inst_req,
    output inst_addr,
    input  inst_ack,
    input  inst_rdata
  );

  modport slave (
    input  inst_req,
    input  inst_addr,
    output inst_ack,
    output inst_rdata
  );
endinterface

// File: rtl/if_fetch.sv
// Instruction fetch stage: single-outstanding request FSM with hold buffer, delayed
// branch redirect, flush with drop-on-ack, misalignment and ack-timeout error capture.
module if_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [7:0]  TIMEOUT  = 8'd255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [5:0]  stall,
  input  logic        flush,
  input  logic [31:0] new_pc,
  input  logic        branch_flag_i,
  input  logic [31:0] branch_target_address_i,
  if_fetch_if.master  imem,
  output logic [31:0] if_pc,
  output logic [31:0] if_inst,
  output logic        stallreq_if,
  output logic        fetch_err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_HOLD = 2'd2,
    S_ERR  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] addr_q, addr_d;
  logic        req_q, req_d;
  logic        pend_q, pend_d;
  logic [31:0] tgt_q, tgt_d;
  logic        drop_q, drop_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] hbuf_pc_q, hbuf_pc_d;
  logic [31:0] hbuf_inst_q, hbuf_inst_d;
  logic [31:0] if_pc_q, if_pc_d;
  logic [31:0] if_inst_q, if_inst_d;
  logic        err_q, err_d;

  logic        hold_s;
  logic        branch_s;
  logic [31:0] next_pc_s;
  logic        unused_stall_s;

  assign hold_s         = stall[0];
  assign branch_s       = branch_flag_i & ~hold_s;
  assign unused_stall_s = ^stall[5:1];

  // Successor PC: a branch resolved this cycle makes the current fetch its delay slot,
  // so it redirects the very next request just like an already-pending target.
  always_comb begin
    if (branch_s) begin
      next_pc_s = branch_target_address_i;
    end else if (pend_q) begin
      next_pc_s = tgt_q;
    end else begin
      next_pc_s = pc_q + 32'd4;
    end
  end

  // Next-state and datapath update logic
  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    pend_d      = pend_q;
    tgt_d       = tgt_q;
    drop_d      = drop_q;
    cnt_d       = cnt_q;
    hbuf_pc_d   = hbuf_pc_q;
    hbuf_inst_d = hbuf_inst_q;
    if_pc_d     = if_pc_q;
    if_inst_d   = if_inst_q;
    err_d       = err_q;

    if (flush) begin
      pc_d        = new_pc;
      pend_d      = 1'b0;
      cnt_d       = 8'd0;
      err_d       = 1'b0;
      if_pc_d     = 32'd0;
      if_inst_d   = 32'd0;
      hbuf_pc_d   = 32'd0;
      hbuf_inst_d = 32'd0;
      state_d     = S_REQ;
      // An unacknowledged request cannot be withdrawn; its data is discarded later.
      drop_d      = (state_q == S_REQ) && !imem.inst_ack;
    end else begin
      if (branch_s) begin
        pend_d = 1'b1;
        tgt_d  = branch_target_address_i;
      end else begin
        pend_d = pend_q;
      end

      case (state_q)
        S_IDLE: begin
          state_d = S_REQ;
        end
        S_REQ: begin
          if (imem.inst_ack) begin
            cnt_d = 8'd0;
            if (drop_q) begin
              drop_d = 1'b0;
            end else if (!hold_s) begin
              if_pc_d   = pc_q;
              if_inst_d = imem.inst_rdata;
              pc_d      = next_pc_s;
              pend_d    = 1'b0;
            end else begin
              hbuf_pc_d   = pc_q;
              hbuf_inst_d = imem.inst_rdata;
              state_d     = S_HOLD;
            end
          end else if ((cnt_q + 8'd1) == TIMEOUT) begin
            state_d = S_ERR;
            err_d   = 1'b1;
            cnt_d   = 8'd0;
            drop_d  = 1'b0;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
        S_HOLD: begin
          if (!hold_s) begin
            if_pc_d   = hbuf_pc_q;
            if_inst_d = hbuf_inst_q;
            pc_d      = next_pc_s;
            pend_d    = 1'b0;
            state_d   = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end
        S_ERR: begin
          state_d = S_ERR;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end

    // A misaligned address is never put on the bus.
    if ((state_d == S_REQ) && !drop_d && (pc_d[1:0] != 2'b00)) begin
      state_d = S_ERR;
      err_d   = 1'b1;
    end else begin
      err_d = err_d;
    end
  end

  // Bus outputs are registered; a dropped request keeps its original address.
  always_comb begin
    req_d = (state_d == S_REQ);
    if (drop_d) begin
      addr_d = addr_q;
    end else begin
      addr_d = pc_d;
    end
  end

  // State, datapath and output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      pc_q        <= RESET_PC;
      addr_q      <= RESET_PC;
      req_q       <= 1'b0;
      pend_q      <= 1'b0;
      tgt_q       <= 32'd0;
      drop_q      <= 1'b0;
      cnt_q       <= 8'd0;
      hbuf_pc_q   <= 32'd0;
      hbuf_inst_q <= 32'd0;
      if_pc_q     <= 32'd0;
      if_inst_q   <= 32'd0;
      err_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      addr_q      <= addr_d;
      req_q       <= req_d;
      pend_q      <= pend_d;
      tgt_q       <= tgt_d;
      drop_q      <= drop_d;
      cnt_q       <= cnt_d;
      hbuf_pc_q   <= hbuf_pc_d;
      hbuf_inst_q <= hbuf_inst_d;
      if_pc_q     <= if_pc_d;
      if_inst_q   <= if_inst_d;
      err_q       <= err_d;
    end
  end

  // Stall request: waiting on memory in REQ, or parked in ERR.
  always_comb begin
    if (state_q == S_ERR) begin
      stallreq_if = 1'b1;
    end else if (state_q == S_REQ) begin
      stallreq_if = !imem.inst_ack;
    end else begin
      stallreq_if = 1'b0;
    end
  end

  assign imem.inst_req  = req_q;
  assign imem.inst_addr = addr_q;
  assign if_pc          = if_pc_q;
  assign if_inst        = if_inst_q;
  assign fetch_err      = err_q;

endmodule

// File: doc/if_fetch.md
IF_FETCH -- requirements
Module: if_fetch

Interface
REQ-001 Parameter RESET_PC, 32'h00000000, PC loaded on reset.
REQ-002 Parameter TIMEOUT, 8'd255, max cycles waiting for inst_ack before error.
REQ-003 clk  in  1  sole clock; all state updates on posedge clk.
REQ-004 rst  in  1  reset, asynchronous, active-low (asserted at 0).
REQ-005 stall  in  6  pipeline stall vector; only stall[0] (PC/fetch hold) is used.
REQ-006 flush  in  1  exception/flush redirect, highest priority.
REQ-007 new_pc  in  32  redirect address accompanying flush.
REQ-008 branch_flag_i  in  1  branch taken, from decode.
REQ-009 branch_target_address_i  in  32  branch target.
REQ-010 inst_req  out  1  instruction memory request.
REQ-011 inst_addr  out  32  fetch address; stable while inst_req=1 and no ack.
REQ-012 inst_ack  in  1  memory accepted request; inst_rdata valid same cycle.
REQ-013 inst_rdata  in  32  fetched instruction word.
REQ-014 if_pc  out  32  PC of delivered instruction (registered).
REQ-015 if_inst  out  32  delivered instruction (registered).
REQ-016 stallreq_if  out  1  fetch stall request to stall controller.
REQ-017 fetch_err  out  1  sticky misalign/timeout error.

Function
REQ-018 States SHALL be IDLE, REQ, HOLD, ERR; IDLE lasts one cycle after reset release, then REQ.
REQ-019 In REQ: inst_req=1, inst_addr=pc; stallreq_if=1 until cycle inst_ack=1 sampled.
REQ-020 inst_addr SHALL NOT change between request assertion and ack (no mid-handshake cancellation).
REQ-021 REQ, inst_ack=1, stall[0]=0: if_pc<=pc, if_inst<=inst_rdata, pc<=next_pc, stay REQ; next request issued following cycle (1 instruction per 2 cycles minimum with zero-wait memory is NOT allowed: zero-wait memory SHALL sustain 1 instruction/cycle, inst_req held high with new address).
REQ-022 REQ, inst_ack=1, stall[0]=1: inst_rdata and pc captured into hold buffer, go HOLD; stallreq_if=0 in HOLD.
REQ-023 HOLD, stall[0]=0: buffer presented on if_pc/if_inst, pc<=next_pc, go REQ; HOLD, stall[0]=1: outputs and buffer unchanged.
REQ-024 next_pc = pending target if redirect pending, else pc+4 (mod 2^32, wrap from 32'hFFFFFFFC to 0).
REQ-025 branch_flag_i=1 with stall[0]=0 SHALL latch branch_target_address_i as pending target; in-flight/current fetch is the delay slot and is delivered normally; pending cleared when consumed.
REQ-026 if_pc/if_inst SHALL hold last values on cycles with no delivery.
REQ-027 flush=1 (any state, regardless of stall): pc<=new_pc, pending target cleared, hold buffer discarded, if_pc/if_inst<=0 next cycle, fetch_err cleared.
REQ-028 flush while request outstanding without ack: drop flag set, old address held until ack, acked data discarded, then new_pc requested next cycle.
REQ-029 flush coinciding with ack: data discarded; new_pc requested next cycle.
REQ-030 Any pc with pc[1:0]!=0 about to be requested: no request issued, fetch_err=1, go ERR.
REQ-031 Wait counter (8 bit) counts cycles in REQ without ack; reaching TIMEOUT: inst_req=0, fetch_err=1, go ERR; counter clears on ack or flush.
REQ-032 ERR: inst_req=0, stallreq_if=1; exit only via flush (to REQ with new_pc).
REQ-033 Priority: flush > ack handling > branch latch.

Reset
REQ-034 rst=0 asynchronously forces: pc=RESET_PC, state=IDLE, inst_req=0, inst_addr=RESET_PC, if_pc=0, if_inst=0, stallreq_if=0, fetch_err=0, pending/drop/counter cleared.
REQ-035 Reset mid-handshake abandons the request; first request after release uses RESET_PC.

Verification
REQ-036 Reset release, ack every cycle, data=addr^32'hA5A5A5A5 -> if_pc 0,4,8,... one per cycle from cycle 2, if_inst matching.
REQ-037 ack at addr 0x10 with stall[0]=1 for 3 cycles -> HOLD, stallreq_if=0, outputs unchanged; on release if_pc=0x10 delivered, next req 0x14.
REQ-038 branch_flag_i=1 target 0x100 while fetching 0x20 -> 0x20 delivered (delay slot), next inst_addr=0x100.
REQ-039 flush new_pc=0x80 while 0x40 outstanding, ack 2 cycles later -> 0x40 data dropped, if_pc/if_inst=0, next inst_addr=0x80.
REQ-040 flush new_pc=0x82 -> no inst_req, fetch_err=1, stallreq_if=1; flush new_pc=0x84 -> fetch_err=0, req 0x84.
REQ-041 No ack for 255 cycles -> fetch_err=1, inst_req=0 in cycle 256; rst=0 mid-wait -> all outputs at reset values immediately.
